// File: rtl/timer_pkg.sv
// Shared definitions for the microwave timer control stage:
// FSM state encoding and BCD entry limits.
package timer_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] KEY_MAX_DIGIT = 4'd9;
    localparam logic [DIGIT_W-1:0] SEC_TENS_MAX  = 4'd5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ENTRY = 3'd1,
        LOAD  = 3'd2,
        RUN   = 3'd3,
        PAUSE = 3'd4,
        DONE  = 3'd5
    } state_t;

    typedef logic [DIGIT_W-1:0] digit_t;

endpackage

// File: rtl/bcd_entry_reg.sv
// Three-digit M:SS keypad entry register; new digits shift in
// at the seconds-ones position and push older digits left.
import timer_pkg::*;

module bcd_entry_reg (
    input  logic   clk,
    input  logic   clear,
    input  logic   sync_clr,
    input  logic   shift,
    input  digit_t digit,
    output digit_t min,
    output digit_t sec_tens,
    output digit_t sec_ones
);

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            min      <= '0;
            sec_tens <= '0;
            sec_ones <= '0;
        end else if (sync_clr) begin
            min      <= '0;
            sec_tens <= '0;
            sec_ones <= '0;
        end else if (shift) begin
            min      <= sec_tens;
            sec_tens <= sec_ones;
            sec_ones <= digit;
        end
    end

endmodule

// File: rtl/timer_entry_ctrl.sv
// Keypad entry and cooking-cycle FSM for the microwave timer;
// drives the counter load bus, load strobe and gated count enable.
import timer_pkg::*;

module timer_entry_ctrl (
    input  logic       clk,
    input  logic       clear,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       start,
    input  logic       stop,
    input  logic       door_closed,
    input  logic       tick_1hz,
    input  logic       all_zero,
    output logic [3:0] data_min,
    output logic [3:0] data_sec_tens,
    output logic [3:0] data_sec_ones,
    output logic       loadn,
    output logic       count_en,
    output logic [2:0] state,
    output logic       done,
    output logic       entry_err
);

    state_t cur;
    state_t nxt;
    logic   err;
    logic   shift_en;
    logic   entry_clr;
    logic   nonzero;

    assign state = cur;

    assign nonzero = (data_min != '0) ||
                     (data_sec_tens != '0) ||
                     (data_sec_ones != '0);

    assign shift_en = key_valid &&
                      (key_code <= KEY_MAX_DIGIT) &&
                      ((cur == IDLE) || (cur == ENTRY));

    // Leaving PAUSE or DONE for IDLE wipes the set time.
    assign entry_clr = ((cur == PAUSE) && stop) ||
                       ((cur == DONE) && (stop || start || key_valid));

    assign count_en = tick_1hz && (cur == RUN) &&
                      door_closed && !all_zero;

    bcd_entry_reg u_entry (
        .clk      (clk),
        .clear    (clear),
        .sync_clr (entry_clr),
        .shift    (shift_en),
        .digit    (key_code),
        .min      (data_min),
        .sec_tens (data_sec_tens),
        .sec_ones (data_sec_ones)
    );

    always_comb begin
        nxt = cur;
        err = 1'b0;
        unique case (cur)
            IDLE: begin
                if (shift_en) nxt = ENTRY;
            end
            ENTRY: begin
                if (start && !stop) begin
                    if (data_sec_tens > SEC_TENS_MAX)
                        err = 1'b1;
                    else if (door_closed && nonzero)
                        nxt = LOAD;
                end
            end
            LOAD: nxt = RUN;
            RUN: begin
                if (all_zero)
                    nxt = DONE;
                else if (stop || !door_closed)
                    nxt = PAUSE;
            end
            PAUSE: begin
                if (stop)
                    nxt = IDLE;
                else if (start && door_closed)
                    nxt = RUN;
            end
            DONE: begin
                if (stop || start || key_valid) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up
    // with the state register.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            cur       <= IDLE;
            loadn     <= 1'b1;
            done      <= 1'b0;
            entry_err <= 1'b0;
        end else begin
            cur       <= nxt;
            loadn     <= (nxt != LOAD);
            done      <= (nxt == DONE);
            entry_err <= err;
        end
    end

endmodule

// File: tb/tb_timer_entry_ctrl.sv
// Directed bench for timer_entry_ctrl with a small BCD down-counter
// model standing in for the minute/seconds counters.
module tb_timer_entry_ctrl;

    logic       clk = 1'b0;
    logic       clear;
    logic       key_valid;
    logic [3:0] key_code;
    logic       start;
    logic       stop;
    logic       door_closed;
    logic       tick_1hz;
    logic       all_zero;
    logic [3:0] data_min;
    logic [3:0] data_sec_tens;
    logic [3:0] data_sec_ones;
    logic       loadn;
    logic       count_en;
    logic [2:0] state;
    logic       done;
    logic       entry_err;

    int vectors = 0;
    int miscompares = 0;
    int en_pulses = 0;
    int load_pulses = 0;
    int eb;
    int lb;

    logic [3:0] cm, ct, co;

    always #5 clk = ~clk;

    timer_entry_ctrl dut (
        .clk           (clk),
        .clear         (clear),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .start         (start),
        .stop          (stop),
        .door_closed   (door_closed),
        .tick_1hz      (tick_1hz),
        .all_zero      (all_zero),
        .data_min      (data_min),
        .data_sec_tens (data_sec_tens),
        .data_sec_ones (data_sec_ones),
        .loadn         (loadn),
        .count_en      (count_en),
        .state         (state),
        .done          (done),
        .entry_err     (entry_err)
    );

    // Counter model: parallel load on loadn low, BCD decrement on count_en
    always @(posedge clk or posedge clear) begin
        if (clear) begin
            cm <= 4'd0;
            ct <= 4'd0;
            co <= 4'd0;
        end else if (!loadn) begin
            cm <= data_min;
            ct <= data_sec_tens;
            co <= data_sec_ones;
        end else if (count_en) begin
            if (co != 4'd0) begin
                co <= co - 4'd1;
            end else begin
                co <= 4'd9;
                if (ct != 4'd0) begin
                    ct <= ct - 4'd1;
                end else begin
                    ct <= 4'd5;
                    cm <= cm - 4'd1;
                end
            end
        end
    end

    assign all_zero = (cm == 4'd0) && (ct == 4'd0) && (co == 4'd0);

    always @(posedge clk) begin
        if (count_en) en_pulses <= en_pulses + 1;
        if (!loadn) load_pulses <= load_pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        step();
        key_valid = 1'b0;
    endtask

    function automatic logic [11:0] data();
        return {data_min, data_sec_tens, data_sec_ones};
    endfunction

    function automatic logic [11:0] cnt();
        return {cm, ct, co};
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        clear = 1'b1;
        key_valid = 1'b0;
        key_code = 4'd0;
        start = 1'b0;
        stop = 1'b0;
        door_closed = 1'b1;
        tick_1hz = 1'b0;
        #3;
        check("rst_state", 32'(state), 32'd0);
        check("rst_data", 32'(data()), 32'h000);
        check("rst_loadn", 32'(loadn), 32'd1);
        check("rst_count_en", 32'(count_en), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(entry_err), 32'd0);
        #10;
        clear = 1'b0;
        step();

        // 1:30 entry, load and full countdown
        press(4'd1);
        check("k1_state", 32'(state), 32'd1);
        check("k1_data", 32'(data()), 32'h001);
        press(4'd3);
        press(4'd0);
        check("k130_data", 32'(data()), 32'h130);
        start = 1'b1;
        step();
        start = 1'b0;
        check("load_state", 32'(state), 32'd2);
        check("load_loadn", 32'(loadn), 32'd0);
        step();
        check("run_state", 32'(state), 32'd3);
        check("run_loadn", 32'(loadn), 32'd1);
        check("load_once", 32'(load_pulses), 32'd1);
        check("cnt_loaded", 32'(cnt()), 32'h130);
        check("hold_data", 32'(data()), 32'h130);
        eb = en_pulses;
        for (int i = 0; i < 90; i++) begin
            tick_1hz = 1'b1;
            step();
            tick_1hz = 1'b0;
            if (i < 89) step();
        end
        check("cd_pulses", 32'(en_pulses - eb), 32'd90);
        check("cd_zero", 32'(all_zero), 32'd1);
        check("cd_still_run", 32'(state), 32'd3);
        step();
        check("done_state", 32'(state), 32'd5);
        check("done_flag", 32'(done), 32'd1);
        tick_1hz = 1'b1;
        #1;
        check("done_no_en", 32'(count_en), 32'd0);
        step();
        tick_1hz = 1'b0;
        check("no_wrap", 32'(cnt()), 32'h000);
        check("done_pulses", 32'(en_pulses - eb), 32'd90);
        press(4'd5);
        check("exit_state", 32'(state), 32'd0);
        check("exit_data", 32'(data()), 32'h000);
        check("exit_done", 32'(done), 32'd0);

        // 1:75 is rejected
        press(4'd1);
        press(4'd7);
        press(4'd5);
        lb = load_pulses;
        start = 1'b1;
        step();
        start = 1'b0;
        check("err_pulse", 32'(entry_err), 32'd1);
        check("err_state", 32'(state), 32'd1);
        check("err_loadn", 32'(loadn), 32'd1);
        step();
        check("err_clear", 32'(entry_err), 32'd0);
        check("err_no_load", 32'(load_pulses - lb), 32'd0);

        // four keys keep the last three; non-digit ignored
        press(4'd1);
        press(4'd2);
        press(4'd3);
        press(4'd4);
        check("k1234_data", 32'(data()), 32'h234);
        press(4'd12);
        check("k12_data", 32'(data()), 32'h234);
        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        check("ss_state", 32'(state), 32'd1);
        check("ss_loadn", 32'(loadn), 32'd1);

        // door-open pause and resume without reload
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("r2_state", 32'(state), 32'd3);
        check("r2_cnt", 32'(cnt()), 32'h234);
        lb = load_pulses;
        for (int i = 0; i < 2; i++) begin
            tick_1hz = 1'b1;
            step();
            tick_1hz = 1'b0;
            step();
        end
        check("r2_cnt2", 32'(cnt()), 32'h232);
        door_closed = 1'b0;
        tick_1hz = 1'b1;
        #1;
        check("door_en", 32'(count_en), 32'd0);
        step();
        tick_1hz = 1'b0;
        check("door_pause", 32'(state), 32'd4);
        eb = en_pulses;
        for (int i = 0; i < 5; i++) begin
            tick_1hz = 1'b1;
            step();
            tick_1hz = 1'b0;
            step();
        end
        check("open_pulses", 32'(en_pulses - eb), 32'd0);
        check("open_state", 32'(state), 32'd4);
        door_closed = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        check("resume_state", 32'(state), 32'd3);
        step();
        check("resume_noload", 32'(load_pulses - lb), 32'd0);
        check("resume_cnt", 32'(cnt()), 32'h232);
        stop = 1'b1;
        tick_1hz = 1'b1;
        #1;
        check("stop_tick_en", 32'(count_en), 32'd1);
        step();
        stop = 1'b0;
        tick_1hz = 1'b0;
        check("stop_pause", 32'(state), 32'd4);
        check("stop_cnt", 32'(cnt()), 32'h231);
        check("pause_data", 32'(data()), 32'h234);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("cancel_state", 32'(state), 32'd0);
        check("cancel_data", 32'(data()), 32'h000);

        // asynchronous clear mid-RUN
        press(4'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("r3_state", 32'(state), 32'd3);
        tick_1hz = 1'b1;
        #2;
        clear = 1'b1;
        #1;
        check("clr_state", 32'(state), 32'd0);
        check("clr_data", 32'(data()), 32'h000);
        check("clr_en", 32'(count_en), 32'd0);
        check("clr_loadn", 32'(loadn), 32'd1);
        check("clr_done", 32'(done), 32'd0);
        clear = 1'b0;
        tick_1hz = 1'b0;
        step();
        press(4'd7);
        check("k7_state", 32'(state), 32'd1);
        check("k7_data", 32'(data()), 32'h007);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
